// File: rtl/cr_wdt_pkg.sv
// Shared definitions for the cr_wdt watchdog: register offsets, keys, CTRL bits, FSM states.
package cr_wdt_pkg;

   // Word index of each register, i.e. address bits [4:2]
   localparam logic [2:0] REG_CTRL = 3'd0;
   localparam logic [2:0] REG_LOAD = 3'd1;
   localparam logic [2:0] REG_VAL  = 3'd2;
   localparam logic [2:0] REG_KICK = 3'd3;
   localparam logic [2:0] REG_STAT = 3'd4;
   localparam logic [2:0] REG_LOCK = 3'd5;

   localparam logic [31:0] WDT_KICK_KEY   = 32'h5A5A_A5A5;
   localparam logic [31:0] WDT_UNLOCK_KEY = 32'h1ACC_E551;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_INTEN   = 1;
   localparam int CTRL_RSTEN   = 2;
   localparam int CTRL_DBGSTOP = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STAGE1,
      ST_STAGE2,
      ST_RSTREQ
   } wdt_state_e;

   // One decoded bus access as seen in the sel cycle
   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [2:0]  idx;
      logic [31:0] wdata;
   } wdt_req_t;

endpackage

// File: rtl/cr_wdt_cnt.sv
// Watchdog core: tick gating, down-counter, two-stage expiry FSM, INTPEND and the sticky reset request.
module cr_wdt_cnt
   import cr_wdt_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       ctrl,
   input  logic             core_dbgon,
   input  logic [CNT_W-1:0] load,
   input  logic             en_on,
   input  logic             en_off,
   input  logic             kick,
   input  logic             intpend_clr,
   output logic [CNT_W-1:0] val,
   output logic             intpend,
   output logic             rst_req
);

   wdt_state_e       state_q, state_d;
   logic [CNT_W-1:0] val_q, val_d;
   logic             intpend_q, intpend_d;
   logic             rst_req_q, rst_req_d;
   logic             tick;

   always_comb begin
      tick      = ctrl[CTRL_EN] & ~(ctrl[CTRL_DBGSTOP] & core_dbgon);
      state_d   = state_q;
      val_d     = val_q;
      // An expiry below overrides the clear, so a same-cycle set wins
      intpend_d = intpend_q & ~intpend_clr;
      rst_req_d = rst_req_q;
      case (state_q)
         ST_IDLE: begin
            if (en_on) begin
               val_d   = load;
               state_d = ST_STAGE1;
            end
         end
         ST_STAGE1, ST_STAGE2: begin
            if (en_off) begin
               state_d = ST_IDLE;
            end else if (kick) begin
               val_d   = load;
               state_d = ST_STAGE1;
            end else if (tick) begin
               if (val_q != '0) begin
                  val_d = val_q - 1'b1;
               end else if (state_q == ST_STAGE2 && ctrl[CTRL_RSTEN]) begin
                  rst_req_d = 1'b1;
                  state_d   = ST_RSTREQ;
               end else begin
                  intpend_d = 1'b1;
                  val_d     = load;
                  state_d   = ST_STAGE2;
               end
            end
         end
         default: ; // RSTREQ is left only through reset
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         val_q     <= '0;
         intpend_q <= 1'b0;
         rst_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         val_q     <= val_d;
         intpend_q <= intpend_d;
         rst_req_q <= rst_req_d;
      end
   end

   assign val     = val_q;
   assign intpend = intpend_q;
   assign rst_req = rst_req_q;

endmodule

// File: rtl/cr_wdt_top.sv
// TCIP watchdog slave: register decode, one-cycle cmplt/rdata response and optional lock.
// Define CR_WDT_LOCK_EN to add the LOCK register that write-protects CTRL and LOAD.
module cr_wdt_top
   import cr_wdt_pkg::*;
#(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] KICK_KEY = WDT_KICK_KEY
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst,
   input  logic        tcipif_wdt_sel,
   input  logic [15:0] tcipif_wdt_addr,
   input  logic        tcipif_wdt_write,
   input  logic [31:0] tcipif_wdt_wdata,
   input  logic        core_dbgon,
   output logic        wdt_tcipif_cmplt,
   output logic [31:0] wdt_tcipif_rdata,
   output logic        wdt_pad_int_vld,
   output logic        wdt_pad_rst_req
);

   wdt_req_t         req;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic             cmplt_q, cmplt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             int_vld_q, int_vld_d;
   logic             locked;
   logic             cfg_wr, ctrl_we, load_we, kick, intpend_clr;
   logic [CNT_W-1:0] val;
   logic             intpend, rst_req;
   logic             unused_addr;

   assign unused_addr = ^{tcipif_wdt_addr[15:5], tcipif_wdt_addr[1:0]};

   always_comb begin
      req.wr    = tcipif_wdt_sel & tcipif_wdt_write;
      req.rd    = tcipif_wdt_sel & ~tcipif_wdt_write;
      req.idx   = tcipif_wdt_addr[4:2];
      req.wdata = tcipif_wdt_wdata;
   end

`ifdef CR_WDT_LOCK_EN
   logic lock_q, lock_d;

   always_comb begin
      lock_d = lock_q;
      if (req.wr && req.idx == REG_LOCK) lock_d = (req.wdata != WDT_UNLOCK_KEY);
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) lock_q <= 1'b0;
      else        lock_q <= lock_d;
   end

   assign locked = lock_q;
`else
   assign locked = 1'b0;
`endif

   always_comb begin
      cfg_wr      = req.wr & ~locked;
      ctrl_we     = cfg_wr & (req.idx == REG_CTRL);
      load_we     = cfg_wr & (req.idx == REG_LOAD);
      kick        = req.wr & (req.idx == REG_KICK) & (req.wdata == KICK_KEY);
      intpend_clr = req.wr & (req.idx == REG_STAT) & req.wdata[0];
      ctrl_d      = ctrl_we ? req.wdata[3:0] : ctrl_q;
      load_d      = load_we ? req.wdata[CNT_W-1:0] : load_q;
      cmplt_d     = tcipif_wdt_sel;
      int_vld_d   = intpend & ctrl_q[CTRL_INTEN];
      // Read data reflects the registers before any write in the same cycle
      rdata_d     = '0;
      if (req.rd) begin
         case (req.idx)
            REG_CTRL: rdata_d[3:0]       = ctrl_q;
            REG_LOAD: rdata_d[CNT_W-1:0] = load_q;
            REG_VAL:  rdata_d[CNT_W-1:0] = val;
            REG_STAT: rdata_d[1:0]       = {rst_req, intpend};
            REG_LOCK: rdata_d[0]         = locked;
            default:  rdata_d            = '0;
         endcase
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         cmplt_q   <= 1'b0;
         rdata_q   <= '0;
         int_vld_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         cmplt_q   <= cmplt_d;
         rdata_q   <= rdata_d;
         int_vld_q <= int_vld_d;
      end
   end

   cr_wdt_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk         (forever_cpuclk),
      .rst         (cpurst),
      .ctrl        (ctrl_q),
      .core_dbgon  (core_dbgon),
      .load        (load_q),
      .en_on       (ctrl_we & req.wdata[CTRL_EN]),
      .en_off      (ctrl_we & ~req.wdata[CTRL_EN]),
      .kick        (kick),
      .intpend_clr (intpend_clr),
      .val         (val),
      .intpend     (intpend),
      .rst_req     (rst_req)
   );

   assign wdt_tcipif_cmplt = cmplt_q;
   assign wdt_tcipif_rdata = rdata_q;
   assign wdt_pad_int_vld  = int_vld_q;
   assign wdt_pad_rst_req  = rst_req;

endmodule

// File: tb/tb_cr_wdt_top.sv
// Scoreboard bench for cr_wdt_top: stimulus queues expected responses, a monitor checks each cmplt.
module tb_cr_wdt_top;

   localparam logic [15:0] A_CTRL = 16'h00, A_LOAD = 16'h04, A_VAL = 16'h08;
   localparam logic [15:0] A_KICK = 16'h0C, A_STAT = 16'h10, A_LOCK = 16'h14;
   localparam logic [31:0] KEY = 32'h5A5A_A5A5, BADKEY = 32'h1234_5678, UNLOCK = 32'h1ACC_E551;

   logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, wr = 1'b0, dbg = 1'b0;
   logic [15:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        cmplt, int_vld, rst_req;
   logic [31:0] rdata;
   bit          done = 1'b0;

   typedef struct {
      logic [31:0] rdata;
      bit          pins;
      logic        iv;
      logic        rr;
      int          tag;
   } exp_t;

   exp_t sb[$];
   int   tag_n = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   cr_wdt_top dut (
      .forever_cpuclk   (clk),
      .cpurst           (rst),
      .tcipif_wdt_sel   (sel),
      .tcipif_wdt_addr  (addr),
      .tcipif_wdt_write (wr),
      .tcipif_wdt_wdata (wdata),
      .core_dbgon       (dbg),
      .wdt_tcipif_cmplt (cmplt),
      .wdt_tcipif_rdata (rdata),
      .wdt_pad_int_vld  (int_vld),
      .wdt_pad_rst_req  (rst_req)
   );

   task automatic push(input logic [31:0] r, input bit p, input logic iv, input logic rr);
      exp_t e;
      e.rdata = r; e.pins = p; e.iv = iv; e.rr = rr; e.tag = tag_n;
      tag_n++;
      sb.push_back(e);
   endtask

   task automatic acc(input logic w, input logic [15:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      sel = 1'b1; wr = w; addr = a; wdata = d;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
      acc(1'b1, a, d);
      push(32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd_reg(input logic [15:0] a, input logic [31:0] exp_r);
      acc(1'b0, a, 32'h0);
      push(exp_r, 1'b0, 1'b0, 1'b0);
   endtask

   // Read that also checks the interrupt and reset pins in the cmplt cycle
   task automatic rd_pin(input logic [15:0] a, input logic [31:0] exp_r, input logic iv, input logic rr);
      acc(1'b0, a, 32'h0);
      push(exp_r, 1'b1, iv, rr);
   endtask

   task automatic idle(input int n, input logic d);
      repeat (n) begin
         @(posedge clk); #1;
         sel = 1'b0; wr = 1'b0; dbg = d;
      end
   endtask

   // A read issued together with reset must never complete
   task automatic rst_mid();
      @(posedge clk); #1;
      sel = 1'b1; wr = 1'b0; addr = A_CTRL; rst = 1'b1;
      @(posedge clk); #1;
      sel = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin : stim
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // reset state
      rd_pin(A_CTRL, 0, 1'b0, 1'b0);
      rd_reg(A_VAL, 0);
      rd_reg(A_STAT, 0);
      rd_reg(A_LOAD, 0);
      // stage 1 expiry: INTPEND after 6 ticks, int_vld one cycle later
      wr_reg(A_LOAD, 5);
      wr_reg(A_CTRL, 3);
      rd_reg(A_VAL, 5);
      rd_reg(A_VAL, 4);
      idle(3, 1'b0);
      rd_pin(A_STAT, 0, 1'b0, 1'b0);
      rd_pin(A_VAL, 5, 1'b1, 1'b0);
      rd_pin(A_STAT, 1, 1'b1, 1'b0);
      // kicks in stage 2, then stage-1 re-expiry, then reset request
      wr_reg(A_KICK, BADKEY);
      wr_reg(A_KICK, KEY);
      rd_pin(A_VAL, 5, 1'b1, 1'b0);
      rd_reg(A_STAT, 1);
      wr_reg(A_CTRL, 7);
      wr_reg(A_STAT, 1);
      rd_pin(A_STAT, 0, 1'b0, 1'b0);
      rd_reg(A_VAL, 0);
      rd_pin(A_STAT, 1, 1'b1, 1'b0);
      wr_reg(A_KICK, BADKEY);
      rd_reg(A_VAL, 3);
      idle(2, 1'b0);
      rd_pin(A_STAT, 1, 1'b1, 1'b1);
      rd_pin(A_STAT, 3, 1'b1, 1'b1);
      wr_reg(A_KICK, KEY);
      wr_reg(A_CTRL, 0);
      rd_pin(A_STAT, 3, 1'b0, 1'b1);
      rd_reg(A_CTRL, 0);
      rd_pin(A_VAL, 0, 1'b0, 1'b1);
      // reset during a pending access
      rst_mid();
      rd_pin(A_STAT, 0, 1'b0, 1'b0);
      rd_reg(A_VAL, 0);
      rd_reg(A_LOAD, 0);
      rd_reg(A_CTRL, 0);
      // kick at VAL==0, old LOAD on reload, LOAD=0, W1C against expiry
      wr_reg(A_LOAD, 3);
      wr_reg(A_CTRL, 1);
      idle(3, 1'b0);
      wr_reg(A_KICK, KEY);
      rd_reg(A_STAT, 0);
      rd_reg(A_VAL, 2);
      idle(1, 1'b0);
      wr_reg(A_LOAD, 0);
      rd_reg(A_VAL, 3);
      wr_reg(A_STAT, 1);
      rd_reg(A_STAT, 0);
      wr_reg(A_STAT, 1);
      rd_reg(A_STAT, 1);
      rd_reg(A_VAL, 0);
      // debug pause
      wr_reg(A_CTRL, 0);
      wr_reg(A_LOAD, 100);
      wr_reg(A_CTRL, 9);
      idle(10, 1'b1);
      rd_reg(A_VAL, 100);
      wr_reg(A_CTRL, 1);
      idle(10, 1'b1);
      rd_reg(A_VAL, 90);
      idle(1, 1'b0);
      // back-to-back reads, unmapped and write-only offsets
      rd_reg(A_VAL, 88);
      rd_reg(A_STAT, 1);
      rd_reg(16'h1C, 0);
      rd_reg(16'h18, 0);
      rd_reg(A_KICK, 0);
`ifdef CR_WDT_LOCK_EN
      wr_reg(A_LOCK, 0);
      wr_reg(A_LOAD, 9);
      rd_reg(A_LOAD, 100);
      wr_reg(A_CTRL, 0);
      rd_reg(A_CTRL, 1);
      rd_reg(A_LOCK, 1);
      wr_reg(A_LOCK, UNLOCK);
      wr_reg(A_LOAD, 9);
      rd_reg(A_LOAD, 9);
      rd_reg(A_LOCK, 0);
`else
      wr_reg(A_LOCK, 0);
      rd_reg(A_LOCK, 0);
      wr_reg(A_LOAD, 9);
      rd_reg(A_LOAD, 9);
`endif
      idle(3, 1'b0);
      done = 1'b1;
   end

   initial begin : mon
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (cmplt) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_cmplt rdata=%h", rdata);
            end else begin
               e = sb.pop_front();
               if (rdata !== e.rdata || (e.pins && (int_vld !== e.iv || rst_req !== e.rr))) begin
                  n_err++;
                  $display("FAIL vec%0d got rdata=%h int=%b rst=%b, want rdata=%h int=%b rst=%b (pins %0d)",
                           e.tag, rdata, int_vld, rst_req, e.rdata, e.iv, e.rr, e.pins);
               end
            end
         end else if (rdata !== 32'h0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_rdata got %h want 0", rdata);
         end
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL missing_cmplt got %0d outstanding want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
